// File: rtl/reg_field_ext.sv
// Register field cell: one parametrised storage field with compile-time access rules,
// per-byte write strobes, sticky hardware set, optional event counter and registered read port.
module reg_field_ext #(
   parameter int unsigned               FIELD_WIDTH   = 8,
   parameter string                     FIELD_ACCESS  = "RW",
   parameter logic [FIELD_WIDTH-1:0]    FIELD_DEFAULT = '0,
   parameter bit                        CNT_SAT       = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sw_wr_en,
   input  logic [FIELD_WIDTH-1:0]         sw_wr_data,
   input  logic [(FIELD_WIDTH+7)/8-1:0]   sw_be,
   input  logic                           sw_rd_en,
   output logic [FIELD_WIDTH-1:0]         sw_rd_data,
   input  logic                           hw_up_en,
   input  logic [FIELD_WIDTH-1:0]         hw_up_data,
   input  logic [FIELD_WIDTH-1:0]         hw_set,
   input  logic                           hw_inc,
   output logic [FIELD_WIDTH-1:0]         field_q,
   output logic                           field_chg,
   output logic                           cnt_ovf
);

   localparam int unsigned W = FIELD_WIDTH;

   localparam bit IS_RW  = (FIELD_ACCESS == "RW");
   localparam bit IS_RO  = (FIELD_ACCESS == "RO");
   localparam bit IS_WO  = (FIELD_ACCESS == "WO");
   localparam bit IS_W1C = (FIELD_ACCESS == "W1C");
   localparam bit IS_W1S = (FIELD_ACCESS == "W1S");
   localparam bit IS_W1T = (FIELD_ACCESS == "W1T");
   localparam bit IS_RC  = (FIELD_ACCESS == "RC");
   localparam bit IS_CNT = (FIELD_ACCESS == "CNT");
   localparam bit ACCESS_OK = IS_RW | IS_RO | IS_WO | IS_W1C | IS_W1S | IS_W1T | IS_RC | IS_CNT;

   // Reject unsupported configurations at elaboration time
   if (!ACCESS_OK) begin : g_bad_access
      $error("reg_field_ext: unsupported FIELD_ACCESS \"%s\"", FIELD_ACCESS);
   end
   if (FIELD_WIDTH < 1 || FIELD_WIDTH > 64) begin : g_bad_width
      $error("reg_field_ext: FIELD_WIDTH %0d outside 1..64", FIELD_WIDTH);
   end

   logic [W-1:0] rd_data_q, rd_data_d;
   logic [W-1:0] field_d;
   logic         field_chg_q;
   logic         cnt_ovf_q, cnt_ovf_d;
   logic [W-1:0] wm_c;
   logic [W-1:0] wset_c;
   logic [W-1:0] hw_base_c;

   // Per-bit write mask from the byte enables
   for (genvar i = 0; i < FIELD_WIDTH; i++) begin : g_wm
      assign wm_c[i] = sw_wr_en & sw_be[i/8];
   end

   assign wset_c    = wm_c & sw_wr_data;
   assign hw_base_c = hw_up_en ? hw_up_data : field_q;

   // Next field value according to the access mode
   always_comb begin
      field_d   = field_q;
      cnt_ovf_d = 1'b0;
      if (IS_CNT) begin
         if (|wm_c) begin
            field_d = wset_c | (~wm_c & field_q);
         end else if (hw_up_en) begin
            field_d = hw_up_data;
         end else if (hw_inc) begin
            if (&field_q) begin
               cnt_ovf_d = 1'b1;
               field_d   = CNT_SAT ? '1 : '0;
            end else begin
               field_d = field_q + W'(1);
            end
         end
      end else if (IS_RC) begin
         // Read clears, but hardware events arriving with the read are kept
         field_d = (sw_rd_en ? (hw_up_en ? hw_up_data : '0) : hw_base_c) | hw_set;
      end else if (IS_RW || IS_WO) begin
         field_d = (wset_c | (~wm_c & hw_base_c)) | hw_set;
      end else if (IS_W1C) begin
         field_d = (hw_base_c & ~wset_c) | hw_set;
      end else if (IS_W1S) begin
         field_d = hw_base_c | wset_c | hw_set;
      end else if (IS_W1T) begin
         field_d = (hw_base_c ^ wset_c) | hw_set;
      end else begin
         field_d = hw_base_c | hw_set;
      end
   end

   // Read data captures the pre-update value and holds until the next read
   always_comb begin
      rd_data_d = rd_data_q;
      if (sw_rd_en) begin
         rd_data_d = IS_WO ? '0 : field_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         field_q     <= FIELD_DEFAULT;
         rd_data_q   <= '0;
         field_chg_q <= 1'b0;
         cnt_ovf_q   <= 1'b0;
      end else begin
         field_q     <= field_d;
         rd_data_q   <= rd_data_d;
         field_chg_q <= (field_d != field_q);
         cnt_ovf_q   <= cnt_ovf_d;
      end
   end

   assign sw_rd_data = rd_data_q;
   assign field_chg  = field_chg_q;
   assign cnt_ovf    = cnt_ovf_q;

endmodule

// File: tb/tb_reg_field_ext.sv
// Bench for reg_field_ext: nine cells in different access modes driven by directed and random
// stimulus, checked every cycle against a per-bit behavioural model plus literal expectations.
module tb_reg_field_ext;

   localparam int NI = 9;
   localparam int M_RW = 0, M_RO = 1, M_WO = 2, M_W1C = 3, M_W1S = 4, M_W1T = 5, M_RC = 6, M_CNT = 7;
   localparam int          WID  [NI] = '{16, 8, 8, 4, 4, 8, 8, 8, 8};
   localparam int          MODE [NI] = '{M_RW, M_W1C, M_RC, M_CNT, M_CNT, M_WO, M_W1S, M_W1T, M_RO};
   localparam bit          SAT  [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [15:0] DEF  [NI] = '{16'h0, 16'hFF, 16'h3C, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

   logic clk, rst_n;
   logic        wr_en [NI];
   logic [15:0] wd    [NI];
   logic [1:0]  be    [NI];
   logic        rd_en [NI];
   logic        up_en [NI];
   logic [15:0] ud    [NI];
   logic [15:0] hs    [NI];
   logic        inc   [NI];

   logic [15:0] rdd [NI];
   logic [15:0] fq  [NI];
   logic        chg [NI];
   logic        ovf [NI];

   logic [7:0] rd1, rd2, rd5, rd6, rd7, rd8, fq1, fq2, fq5, fq6, fq7, fq8;
   logic [3:0] rd3, rd4, fq3, fq4;

   logic [15:0] m_field [NI];
   logic [15:0] m_rd    [NI];
   logic        m_chg   [NI];
   logic        m_ovf   [NI];

   int  n_err = 0;
   int  n_chk = 0;
   bit  chk_on = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reg_field_ext #(.FIELD_WIDTH(16), .FIELD_ACCESS("RW"), .FIELD_DEFAULT(16'h0), .CNT_SAT(1'b0)) u_rw (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[0]), .sw_wr_data(wd[0]), .sw_be(be[0]),
      .sw_rd_en(rd_en[0]), .sw_rd_data(rdd[0]), .hw_up_en(up_en[0]), .hw_up_data(ud[0]),
      .hw_set(hs[0]), .hw_inc(inc[0]), .field_q(fq[0]), .field_chg(chg[0]), .cnt_ovf(ovf[0]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("W1C"), .FIELD_DEFAULT(8'hFF), .CNT_SAT(1'b0)) u_w1c (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[1]), .sw_wr_data(wd[1][7:0]), .sw_be(be[1][0]),
      .sw_rd_en(rd_en[1]), .sw_rd_data(rd1), .hw_up_en(up_en[1]), .hw_up_data(ud[1][7:0]),
      .hw_set(hs[1][7:0]), .hw_inc(inc[1]), .field_q(fq1), .field_chg(chg[1]), .cnt_ovf(ovf[1]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("RC"), .FIELD_DEFAULT(8'h3C), .CNT_SAT(1'b0)) u_rc (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[2]), .sw_wr_data(wd[2][7:0]), .sw_be(be[2][0]),
      .sw_rd_en(rd_en[2]), .sw_rd_data(rd2), .hw_up_en(up_en[2]), .hw_up_data(ud[2][7:0]),
      .hw_set(hs[2][7:0]), .hw_inc(inc[2]), .field_q(fq2), .field_chg(chg[2]), .cnt_ovf(ovf[2]));

   reg_field_ext #(.FIELD_WIDTH(4), .FIELD_ACCESS("CNT"), .FIELD_DEFAULT(4'h0), .CNT_SAT(1'b0)) u_cnt_wrap (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[3]), .sw_wr_data(wd[3][3:0]), .sw_be(be[3][0]),
      .sw_rd_en(rd_en[3]), .sw_rd_data(rd3), .hw_up_en(up_en[3]), .hw_up_data(ud[3][3:0]),
      .hw_set(hs[3][3:0]), .hw_inc(inc[3]), .field_q(fq3), .field_chg(chg[3]), .cnt_ovf(ovf[3]));

   reg_field_ext #(.FIELD_WIDTH(4), .FIELD_ACCESS("CNT"), .FIELD_DEFAULT(4'h0), .CNT_SAT(1'b1)) u_cnt_sat (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[4]), .sw_wr_data(wd[4][3:0]), .sw_be(be[4][0]),
      .sw_rd_en(rd_en[4]), .sw_rd_data(rd4), .hw_up_en(up_en[4]), .hw_up_data(ud[4][3:0]),
      .hw_set(hs[4][3:0]), .hw_inc(inc[4]), .field_q(fq4), .field_chg(chg[4]), .cnt_ovf(ovf[4]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("WO"), .FIELD_DEFAULT(8'h0), .CNT_SAT(1'b0)) u_wo (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[5]), .sw_wr_data(wd[5][7:0]), .sw_be(be[5][0]),
      .sw_rd_en(rd_en[5]), .sw_rd_data(rd5), .hw_up_en(up_en[5]), .hw_up_data(ud[5][7:0]),
      .hw_set(hs[5][7:0]), .hw_inc(inc[5]), .field_q(fq5), .field_chg(chg[5]), .cnt_ovf(ovf[5]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("W1S"), .FIELD_DEFAULT(8'h0), .CNT_SAT(1'b0)) u_w1s (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[6]), .sw_wr_data(wd[6][7:0]), .sw_be(be[6][0]),
      .sw_rd_en(rd_en[6]), .sw_rd_data(rd6), .hw_up_en(up_en[6]), .hw_up_data(ud[6][7:0]),
      .hw_set(hs[6][7:0]), .hw_inc(inc[6]), .field_q(fq6), .field_chg(chg[6]), .cnt_ovf(ovf[6]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("W1T"), .FIELD_DEFAULT(8'h0), .CNT_SAT(1'b0)) u_w1t (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[7]), .sw_wr_data(wd[7][7:0]), .sw_be(be[7][0]),
      .sw_rd_en(rd_en[7]), .sw_rd_data(rd7), .hw_up_en(up_en[7]), .hw_up_data(ud[7][7:0]),
      .hw_set(hs[7][7:0]), .hw_inc(inc[7]), .field_q(fq7), .field_chg(chg[7]), .cnt_ovf(ovf[7]));

   reg_field_ext #(.FIELD_WIDTH(8), .FIELD_ACCESS("RO"), .FIELD_DEFAULT(8'h0), .CNT_SAT(1'b0)) u_ro (
      .clk(clk), .rst_n(rst_n), .sw_wr_en(wr_en[8]), .sw_wr_data(wd[8][7:0]), .sw_be(be[8][0]),
      .sw_rd_en(rd_en[8]), .sw_rd_data(rd8), .hw_up_en(up_en[8]), .hw_up_data(ud[8][7:0]),
      .hw_set(hs[8][7:0]), .hw_inc(inc[8]), .field_q(fq8), .field_chg(chg[8]), .cnt_ovf(ovf[8]));

   assign rdd[1] = 16'(rd1);  assign fq[1] = 16'(fq1);
   assign rdd[2] = 16'(rd2);  assign fq[2] = 16'(fq2);
   assign rdd[3] = 16'(rd3);  assign fq[3] = 16'(fq3);
   assign rdd[4] = 16'(rd4);  assign fq[4] = 16'(fq4);
   assign rdd[5] = 16'(rd5);  assign fq[5] = 16'(fq5);
   assign rdd[6] = 16'(rd6);  assign fq[6] = 16'(fq6);
   assign rdd[7] = 16'(rd7);  assign fq[7] = 16'(fq7);
   assign rdd[8] = 16'(rd8);  assign fq[8] = 16'(fq8);

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Field update rules evaluated bit by bit (or as plain arithmetic for counters)
   function automatic void model_next(input int k, output logic [15:0] nf, output logic ov);
      logic [15:0] f, wmsk, mask;
      logic        cur;
      int unsigned v;
      f    = m_field[k];
      mask = 16'((32'd1 << WID[k]) - 32'd1);
      wmsk = '0;
      for (int b = 0; b < WID[k]; b++) wmsk[b] = wr_en[k] & be[k][b / 8];
      ov = 1'b0;
      nf = f;
      if (MODE[k] == M_CNT) begin
         if (wmsk != 16'h0)   nf = (f & ~wmsk) | (wd[k] & wmsk);
         else if (up_en[k])   nf = ud[k] & mask;
         else if (inc[k]) begin
            v = 32'(f) + 32'd1;
            if (v > 32'(mask)) begin
               ov = 1'b1;
               nf = SAT[k] ? mask : 16'h0;
            end else begin
               nf = 16'(v);
            end
         end
      end else begin
         for (int b = 0; b < WID[k]; b++) begin
            cur = up_en[k] ? ud[k][b] : f[b];
            case (MODE[k])
               M_RW, M_WO: if (wmsk[b]) cur = wd[k][b];
               M_W1C:      if (wmsk[b] && wd[k][b]) cur = 1'b0;
               M_W1S:      if (wmsk[b] && wd[k][b]) cur = 1'b1;
               M_W1T:      if (wmsk[b] && wd[k][b]) cur = ~cur;
               M_RC:       if (rd_en[k]) cur = up_en[k] & ud[k][b];
               default:    ;
            endcase
            nf[b] = cur | hs[k][b];
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            m_field[k] <= DEF[k];
            m_rd[k]    <= 16'h0;
            m_chg[k]   <= 1'b0;
            m_ovf[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            automatic logic [15:0] nf;
            automatic logic        ov;
            model_next(k, nf, ov);
            m_field[k] <= nf;
            m_chg[k]   <= (nf != m_field[k]);
            m_ovf[k]   <= ov;
            if (rd_en[k]) m_rd[k] <= (MODE[k] == M_WO) ? 16'h0 : m_field[k];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("field_q[%0d]", k),    fq[k],         m_field[k]);
            check($sformatf("sw_rd_data[%0d]", k), rdd[k],        m_rd[k]);
            check($sformatf("field_chg[%0d]", k),  16'(chg[k]),   16'(m_chg[k]));
            check($sformatf("cnt_ovf[%0d]", k),    16'(ovf[k]),   16'(m_ovf[k]));
         end
      end
   end

   task automatic idle();
      for (int k = 0; k < NI; k++) begin
         wr_en[k] = 1'b0; wd[k] = 16'h0; be[k] = 2'b00; rd_en[k] = 1'b0;
         up_en[k] = 1'b0; ud[k] = 16'h0; hs[k] = 16'h0; inc[k] = 1'b0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < NI; k++) begin
         wr_en[k] = ($urandom % 4) == 0;
         wd[k]    = 16'($urandom);
         be[k]    = 2'($urandom);
         rd_en[k] = ($urandom % 5) == 0;
         up_en[k] = ($urandom % 8) == 0;
         ud[k]    = 16'($urandom);
         hs[k]    = (($urandom % 6) == 0) ? 16'(32'd1 << ($urandom % 16)) : 16'h0;
         inc[k]   = ($urandom % 3) != 0;
      end
   endtask

   int n_ovf;

   initial begin
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (2) cyc();
      check("rst_w1c_default", fq[1], 16'h00FF);
      check("rst_rc_default",  fq[2], 16'h003C);
      check("rst_rd_data",     rdd[2], 16'h0);
      check("rst_chg",         16'(chg[0]), 16'h0);
      rst_n = 1'b1;
      cyc();

      // RW upper-byte write
      wr_en[0] = 1'b1; wd[0] = 16'hA5A5; be[0] = 2'b10;
      cyc(); idle();
      check("rw_be_write", fq[0], 16'hA500);
      check("rw_chg_pulse", 16'(chg[0]), 16'h1);
      cyc();
      check("rw_chg_drop", 16'(chg[0]), 16'h0);

      // Read and write together return the old value
      wr_en[0] = 1'b1; wd[0] = 16'h1234; be[0] = 2'b11; rd_en[0] = 1'b1;
      cyc(); idle();
      check("rw_rd_old", rdd[0], 16'hA500);
      check("rw_wr_new", fq[0], 16'h1234);

      // W1C with concurrent hardware set
      wr_en[1] = 1'b1; wd[1] = 16'h0F; be[1] = 2'b01; hs[1] = 16'h01;
      cyc(); idle();
      check("w1c_set_wins", fq[1], 16'h00F1);
      wr_en[1] = 1'b1; wd[1] = 16'h01; be[1] = 2'b01;
      cyc(); idle();
      check("w1c_clear", fq[1], 16'h00F0);

      // Read-clear with an event in the read cycle
      rd_en[2] = 1'b1; hs[2] = 16'h80;
      cyc(); idle();
      check("rc_rd_data", rdd[2], 16'h003C);
      check("rc_event_kept", fq[2], 16'h0080);
      cyc();
      check("rc_rd_hold", rdd[2], 16'h003C);

      // Wrapping counter: 16 increments
      n_ovf = 0;
      inc[3] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) begin
            @(posedge clk); #1; inc[3] = 1'b0;
         end else begin
            cyc();
         end
         n_ovf += int'(ovf[3]);
         if (i == 15) check("cnt_wrap_at15", fq[3], 16'hF);
      end
      check("cnt_wrap_zero", fq[3], 16'h0);
      check("cnt_wrap_ovf", 16'(ovf[3]), 16'h1);
      check("cnt_wrap_npulse", 16'(n_ovf), 16'd1);
      cyc();
      check("cnt_wrap_ovf_drop", 16'(ovf[3]), 16'h0);

      // Saturating counter: 20 increments
      n_ovf = 0;
      inc[4] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         n_ovf += int'(ovf[4]);
         if (i == 15) check("cnt_sat_no_ovf15", 16'(ovf[4]), 16'h0);
      end
      check("cnt_sat_hold", fq[4], 16'hF);
      check("cnt_sat_npulse", 16'(n_ovf), 16'd5);
      wr_en[4] = 1'b1; wd[4] = 16'h3; be[4] = 2'b01; inc[4] = 1'b1;
      cyc(); idle();
      check("cnt_sat_load", fq[4], 16'h3);
      check("cnt_sat_load_ovf", 16'(ovf[4]), 16'h0);

      // Write-only reads as zero
      wr_en[5] = 1'b1; wd[5] = 16'h5A; be[5] = 2'b01;
      cyc(); idle();
      rd_en[5] = 1'b1;
      cyc(); idle();
      check("wo_rd_zero", rdd[5], 16'h0);
      check("wo_field", fq[5], 16'h005A);

      // W1S, W1T, RO
      wr_en[6] = 1'b1; wd[6] = 16'h0F; be[6] = 2'b01;
      wr_en[7] = 1'b1; wd[7] = 16'h33; be[7] = 2'b01; hs[7] = 16'h01;
      wr_en[8] = 1'b1; wd[8] = 16'hFF; be[8] = 2'b01;
      cyc(); idle();
      check("w1s_set", fq[6], 16'h000F);
      check("w1t_toggle1", fq[7], 16'h0033);
      check("ro_ignore_wr", fq[8], 16'h0);
      wr_en[6] = 1'b1; wd[6] = 16'h00; be[6] = 2'b01;
      wr_en[7] = 1'b1; wd[7] = 16'h33; be[7] = 2'b01; hs[7] = 16'h01;
      up_en[8] = 1'b1; ud[8] = 16'h42;
      cyc(); idle();
      check("w1s_zero_noop", fq[6], 16'h000F);
      check("w1t_toggle2", fq[7], 16'h0001);
      check("ro_hw_load", fq[8], 16'h0042);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         randomize_inputs();
         cyc();
      end

      // Asynchronous reset in the middle of counting
      idle();
      inc[3] = 1'b1; inc[4] = 1'b1;
      repeat (5) cyc();
      #2 rst_n = 1'b0;
      #1;
      check("arst_cnt", fq[3], 16'h0);
      check("arst_w1c", fq[1], 16'h00FF);
      check("arst_rd", rdd[2], 16'h0);
      check("arst_ovf", 16'(ovf[3]), 16'h0);
      check("arst_chg", 16'(chg[4]), 16'h0);
      idle();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         randomize_inputs();
         cyc();
      end
      idle();
      cyc();
      chk_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
